fsm_sequence_checker: RTL and testbench
=======================================

Name: fsm_sequence_checker

Overview:
- Receive-side companion to the arbitrary-sequence FSM counters: samples a 3-bit count stream and checks it against the fixed dice sequence 1→6→2→3→4→5→1.
- Hunts for the sequence, locks after a run of correct transitions, and keeps an expected-value flywheel while locked.
- Reports mismatches, loss of lock and completed cycles, and keeps a saturating error count for self-test of counter blocks on the board.

Parameters:
LOCK_COUNT, 3, consecutive correct transitions required to enter LOCKED (1..15)
LOSS_COUNT, 2, consecutive mismatches in LOCKED that drop lock (1..15)
ERR_W, 8, width of err_count

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
valid  input  1  sample strobe; num is evaluated only when valid=1
num  input  3  observed count value
clr_err  input  1  synchronous clear of err_count
locked  output  1  high while FSM is in LOCKED
mismatch  output  1  one-cycle pulse: sample in LOCKED did not match expected
cycle_done  output  1  one-cycle pulse: 5→1 transition matched in LOCKED
expected  output  3  succ(prev), or 0 when prev is not in 1..6
err_count  output  ERR_W  saturating count of mismatches seen in LOCKED

Behaviour:
- Successor function: succ(1)=6, succ(6)=2, succ(2)=3, succ(3)=4, succ(4)=5, succ(5)=1. Legal values are 1..6; 0 and 7 are illegal.
- Registered outputs: all outputs update on the clk edge that samples valid=1 and are visible the next cycle (latency 1). With valid=0, nothing changes, and mismatch and cycle_done are 0.
- Reset: state=HUNT, prev=0, good_cnt=0, bad_cnt=0, locked=0, mismatch=0, cycle_done=0, expected=0, err_count=0. Reset mid-operation (including mid-lock) returns to this state in one cycle.
- Hold: a valid sample with num==prev is ignored in all states. No progress and no error.
- HUNT:
  - legal num: prev<=num, good_cnt<=0, go to TRACK.
  - illegal num: stay in HUNT. A counter stuck at 0 never leaves HUNT.
- TRACK:
  - num==succ(prev): prev<=num, good_cnt++. If good_cnt+1==LOCK_COUNT, go to LOCKED with bad_cnt<=0.
  - legal mismatch: prev<=num, good_cnt<=0, stay in TRACK.
  - illegal num: go to HUNT.
  - No mismatch pulse and no err_count change in TRACK.
- LOCKED:
  - num==succ(prev): prev<=num, bad_cnt<=0. cycle_done=1 if prev was 5.
  - Any other value, including illegal: mismatch=1, err_count++ (saturates at 2^ERR_W-1), prev<=succ(prev) (flywheel), bad_cnt++.
  - If bad_cnt+1==LOSS_COUNT: go to HUNT, good_cnt<=0, locked=0.
- clr_err:
  - clr_err alone: err_count<=0.
  - clr_err in the same cycle as a new mismatch: err_count<=1.
  - clr_err has no effect on FSM state.
- Counters: good_cnt and bad_cnt are 4 bits wide.

Test Plan:
- Lock: reset; valid samples 1,6,2,3 -> locked=1 the cycle after sample 3; expected=4; err_count=0; mismatch never asserted.
- Flywheel and cycle pulse (locked, prev=2): feed 4 -> mismatch pulse, err_count=1, expected=4. Then feed 4,5,1 -> locked stays 1, cycle_done pulses on the cycle after 1.
- Loss of lock (locked, prev=3): feed 7 then 2 -> two mismatch pulses, err_count=2, locked=0 after the second; next sample 0 keeps HUNT.
- Holds and gaps (locked): repeat 6,6,6 interleaved with valid=0 cycles -> no mismatch, expected stays 2, locked stays 1.
- Saturation and clear (ERR_W=2): five mismatches separated by correct samples -> err_count=3. Then clr_err with a concurrent mismatch -> err_count=1; clr_err alone -> 0.
- Reset mid-lock: assert reset while locked with err_count=5 -> next cycle all outputs 0; samples 1,6,2,3 re-lock as in the first scenario.

Source files
------------

// File: rtl/fsm_sequence_checker_if.sv
// ---------------------------------------------------------------------------
// fsm_sequence_checker_if
// Bundles the sample stream and the status outputs of the dice-sequence
// checker so the checker and whatever drives it share one port.
//
// Signals:
//   valid      sample strobe, num is only looked at when valid is high
//   num        3-bit observed count value
//   clr_err    synchronous clear of the error counter
//   locked     checker is in LOCKED
//   mismatch   one-cycle pulse, a locked sample differed from the expected value
//   cycle_done one-cycle pulse, a locked 5->1 transition matched
//   expected   successor of the last accepted value, 0 when there is none
//   err_count  saturating count of locked mismatches
//
// Modports:
//   master  drives the sample stream, observes status
//   slave   the checker itself
// ---------------------------------------------------------------------------
interface fsm_sequence_checker_if #(
   parameter int ERR_W = 8
);
   logic             valid;
   logic [2:0]       num;
   logic             clr_err;
   logic             locked;
   logic             mismatch;
   logic             cycle_done;
   logic [2:0]       expected;
   logic [ERR_W-1:0] err_count;

   modport master (
      output valid, num, clr_err,
      input  locked, mismatch, cycle_done, expected, err_count
   );

   modport slave (
      input  valid, num, clr_err,
      output locked, mismatch, cycle_done, expected, err_count
   );
endinterface

// File: rtl/fsm_sequence_checker.sv
// ---------------------------------------------------------------------------
// fsm_sequence_checker
// Receive-side checker for the dice counter sequence 1->6->2->3->4->5->1.
// It hunts for a legal value, tracks correct transitions until it has seen
// LOCK_COUNT in a row, then locks and runs an expected-value flywheel.
// While locked, wrong samples raise a mismatch pulse and bump a saturating
// error counter; LOSS_COUNT mismatches in a row drop it back to hunting.
//
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous, active-high
//   bus    fsm_sequence_checker_if.slave (valid/num/clr_err in,
//          locked/mismatch/cycle_done/expected/err_count out)
// ---------------------------------------------------------------------------
module fsm_sequence_checker #(
   parameter int LOCK_COUNT = 3,
   parameter int LOSS_COUNT = 2,
   parameter int ERR_W      = 8
) (
   input  logic                         clk,
   input  logic                         reset,
   fsm_sequence_checker_if.slave        bus
);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [3:0]       LOCK_C  = 4'(LOCK_COUNT);
   localparam logic [3:0]       LOSS_C  = 4'(LOSS_COUNT);
   localparam logic [ERR_W-1:0] ERR_MAX = '1;

   state_t           state_q, state_d;
   logic [2:0]       prev_q, prev_d;
   logic [3:0]       goodCnt_q, goodCnt_d;
   logic [3:0]       badCnt_q, badCnt_d;
   logic             mismatch_q, mismatch_d;
   logic             cycleDone_q, cycleDone_d;
   logic [ERR_W-1:0] errCnt_q, errCnt_d;

   logic [2:0]       succPrev;
   logic             numLegal;
   logic             errInc;

   // Successor in the dice sequence; 0 marks "no legal predecessor".
   function automatic logic [2:0] succ(input logic [2:0] v);
      case (v)
         3'd1:    succ = 3'd6;
         3'd6:    succ = 3'd2;
         3'd2:    succ = 3'd3;
         3'd3:    succ = 3'd4;
         3'd4:    succ = 3'd5;
         3'd5:    succ = 3'd1;
         default: succ = 3'd0;
      endcase
   endfunction

   assign succPrev = succ(prev_q);
   assign numLegal = (bus.num != 3'd0) && (bus.num != 3'd7);

   // Next-state logic. A sample equal to the last accepted value is a hold
   // and is ignored everywhere, so a slow counter never looks like an error.
   // In LOCKED a bad sample advances prev anyway (flywheel) so that a single
   // glitch does not shift the expected phase of the rest of the stream.
   always_comb begin
      state_d     = state_q;
      prev_d      = prev_q;
      goodCnt_d   = goodCnt_q;
      badCnt_d    = badCnt_q;
      mismatch_d  = 1'b0;
      cycleDone_d = 1'b0;
      errInc      = 1'b0;

      if (bus.valid && (bus.num != prev_q)) begin
         case (state_q)
            HUNT: begin
               if (numLegal) begin
                  prev_d    = bus.num;
                  goodCnt_d = 4'd0;
                  state_d   = TRACK;
               end
            end
            TRACK: begin
               if (!numLegal) begin
                  state_d = HUNT;
               end else if (bus.num == succPrev) begin
                  prev_d    = bus.num;
                  goodCnt_d = goodCnt_q + 4'd1;
                  if (goodCnt_q + 4'd1 == LOCK_C) begin
                     state_d  = LOCKED;
                     badCnt_d = 4'd0;
                  end
               end else begin
                  prev_d    = bus.num;
                  goodCnt_d = 4'd0;
               end
            end
            LOCKED: begin
               if (bus.num == succPrev) begin
                  prev_d      = bus.num;
                  badCnt_d    = 4'd0;
                  cycleDone_d = (prev_q == 3'd5);
               end else begin
                  mismatch_d = 1'b1;
                  errInc     = 1'b1;
                  prev_d     = succPrev;
                  badCnt_d   = badCnt_q + 4'd1;
                  if (badCnt_q + 4'd1 == LOSS_C) begin
                     state_d   = HUNT;
                     goodCnt_d = 4'd0;
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   // Error counter: a clear that coincides with a new mismatch leaves 1 so
   // that mismatch is not lost; otherwise count up and stick at all-ones.
   always_comb begin
      errCnt_d = errCnt_q;
      if (bus.clr_err) begin
         errCnt_d = errInc ? ERR_W'(1) : '0;
      end else if (errInc && (errCnt_q != ERR_MAX)) begin
         errCnt_d = errCnt_q + ERR_W'(1);
      end
   end

   // State register with synchronous reset back to hunting.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= HUNT;
         prev_q      <= 3'd0;
         goodCnt_q   <= 4'd0;
         badCnt_q    <= 4'd0;
         mismatch_q  <= 1'b0;
         cycleDone_q <= 1'b0;
         errCnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         prev_q      <= prev_d;
         goodCnt_q   <= goodCnt_d;
         badCnt_q    <= badCnt_d;
         mismatch_q  <= mismatch_d;
         cycleDone_q <= cycleDone_d;
         errCnt_q    <= errCnt_d;
      end
   end

   // Every output derives straight from registers, so all of them appear
   // one cycle after the sample that caused them.
   assign bus.locked     = (state_q == LOCKED);
   assign bus.mismatch   = mismatch_q;
   assign bus.cycle_done = cycleDone_q;
   assign bus.expected   = succPrev;
   assign bus.err_count  = errCnt_q;

endmodule

// File: tb/tb_fsm_sequence_checker.sv
// ---------------------------------------------------------------------------
// tb_fsm_sequence_checker
// Drives two checkers (ERR_W=8 and ERR_W=2) with the same sample stream.
// A reference model computes the outputs expected after each sample; they
// are queued when the sample is driven and compared one cycle later.
// ---------------------------------------------------------------------------
module tb_fsm_sequence_checker;

   typedef struct {
      logic       locked;
      logic       mismatch;
      logic       cycleDone;
      logic [2:0] expected;
      int         errA;
      int         errB;
   } expT;

   logic clk;
   logic reset;

   fsm_sequence_checker_if #(.ERR_W(8)) busA ();
   fsm_sequence_checker_if #(.ERR_W(2)) busB ();

   fsm_sequence_checker #(.LOCK_COUNT(3), .LOSS_COUNT(2), .ERR_W(8)) dutA (
      .clk   (clk),
      .reset (reset),
      .bus   (busA.slave)
   );

   fsm_sequence_checker #(.LOCK_COUNT(3), .LOSS_COUNT(2), .ERR_W(2)) dutB (
      .clk   (clk),
      .reset (reset),
      .bus   (busB.slave)
   );

   // Free-running clock, 10 time-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;
   expT sbQueue[$];

   // Reference model state: 0=HUNT 1=TRACK 2=LOCKED
   int mState = 0;
   int mPrev  = 0;
   int mGood  = 0;
   int mBad   = 0;
   int mErrA  = 0;
   int mErrB  = 0;
   int nextTab[8] = '{0, 6, 3, 4, 5, 1, 2, 0};

   task automatic checkOutput(input string tag, input int observed, input int required);
      checks++;
      if (observed !== required)
         $display("[TB] FAIL %s observed=%0d required=%0d", tag, observed, required);
      else
         passed++;
   endtask

   // Advance the reference model by one clock and return what the DUT
   // outputs should be afterwards.
   function automatic expT modelStep(input logic rst, input logic v, input int n, input logic clr);
      expT e;
      bit  mis = 0;
      bit  cd  = 0;
      if (rst) begin
         mState = 0; mPrev = 0; mGood = 0; mBad = 0; mErrA = 0; mErrB = 0;
      end else begin
         if (v && n != mPrev) begin
            bit legal = (n >= 1 && n <= 6);
            if (mState == 0) begin
               if (legal) begin mPrev = n; mGood = 0; mState = 1; end
            end else if (mState == 1) begin
               if (!legal) mState = 0;
               else if (n == nextTab[mPrev]) begin
                  mPrev = n; mGood++;
                  if (mGood == 3) begin mState = 2; mBad = 0; end
               end else begin
                  mPrev = n; mGood = 0;
               end
            end else begin
               if (n == nextTab[mPrev]) begin
                  cd = (mPrev == 5); mPrev = n; mBad = 0;
               end else begin
                  mis = 1; mPrev = nextTab[mPrev]; mBad++;
                  if (mBad == 2) begin mState = 0; mGood = 0; end
               end
            end
         end
         if (clr) begin
            mErrA = mis; mErrB = mis;
         end else if (mis) begin
            if (mErrA < 255) mErrA++;
            if (mErrB < 3) mErrB++;
         end
      end
      e.locked    = (mState == 2);
      e.mismatch  = mis;
      e.cycleDone = cd;
      e.expected  = 3'(nextTab[mPrev]);
      e.errA      = mErrA;
      e.errB      = mErrB;
      return e;
   endfunction

   // Drive one cycle of stimulus (called just after a falling edge), push
   // the model's prediction, then compare both DUTs #1 after the rising edge.
   task automatic applyStimulus(input logic rst, input logic v, input int n, input logic clr);
      expT e;
      reset        = rst;
      busA.valid   = v;  busB.valid   = v;
      busA.num     = 3'(n); busB.num  = 3'(n);
      busA.clr_err = clr; busB.clr_err = clr;
      sbQueue.push_back(modelStep(rst, v, n, clr));
      @(posedge clk);
      #1;
      e = sbQueue.pop_front();
      checkOutput("lockedA",   int'(busA.locked),     int'(e.locked));
      checkOutput("mismatchA", int'(busA.mismatch),   int'(e.mismatch));
      checkOutput("cycleA",    int'(busA.cycle_done), int'(e.cycleDone));
      checkOutput("expectedA", int'(busA.expected),   int'(e.expected));
      checkOutput("errA",      int'(busA.err_count),  e.errA);
      checkOutput("lockedB",   int'(busB.locked),     int'(e.locked));
      checkOutput("mismatchB", int'(busB.mismatch),   int'(e.mismatch));
      checkOutput("errB",      int'(busB.err_count),  e.errB);
      @(negedge clk);
   endtask

   task automatic feed(input int n);
      applyStimulus(1'b0, 1'b1, n, 1'b0);
   endtask

   task automatic idle();
      applyStimulus(1'b0, 1'b0, 0, 1'b0);
   endtask

   initial begin
      reset = 1'b1;
      busA.valid = 1'b0; busA.num = 3'd0; busA.clr_err = 1'b0;
      busB.valid = 1'b0; busB.num = 3'd0; busB.clr_err = 1'b0;
      @(negedge clk);

      // Reset state
      applyStimulus(1'b1, 1'b0, 0, 1'b0);
      checkOutput("rstLocked",   int'(busA.locked),    0);
      checkOutput("rstExpected", int'(busA.expected),  0);
      checkOutput("rstErr",      int'(busA.err_count), 0);

      // Lock on 1,6,2,3
      feed(1); feed(6); feed(2);
      checkOutput("preLock", int'(busA.locked), 0);
      feed(3);
      checkOutput("lock",       int'(busA.locked),    1);
      checkOutput("lockExpect", int'(busA.expected),  4);
      checkOutput("lockErr",    int'(busA.err_count), 0);

      // Flywheel and cycle pulse from prev=2
      feed(4); feed(5); feed(1); feed(6); feed(2);
      feed(4);
      checkOutput("flyMis",    int'(busA.mismatch),  1);
      checkOutput("flyErr",    int'(busA.err_count), 1);
      checkOutput("flyExpect", int'(busA.expected),  4);
      feed(4); feed(5); feed(1);
      checkOutput("cycleDone", int'(busA.cycle_done), 1);
      checkOutput("cycleLock", int'(busA.locked),     1);

      // Loss of lock from prev=3
      applyStimulus(1'b1, 1'b0, 0, 1'b0);
      feed(1); feed(6); feed(2); feed(3);
      feed(7);
      checkOutput("lossMis1", int'(busA.mismatch), 1);
      feed(2);
      checkOutput("lossMis2",   int'(busA.mismatch),  1);
      checkOutput("lossErr",    int'(busA.err_count), 2);
      checkOutput("lossLocked", int'(busA.locked),    0);
      feed(0);
      checkOutput("stuckZero", int'(busA.locked), 0);

      // Holds and gaps while locked at prev=6
      applyStimulus(1'b1, 1'b0, 0, 1'b0);
      feed(1); feed(6); feed(2); feed(3); feed(4); feed(5); feed(1); feed(6);
      feed(6); idle(); feed(6); idle(); feed(6);
      checkOutput("holdExpect", int'(busA.expected), 2);
      checkOutput("holdLocked", int'(busA.locked),   1);
      checkOutput("holdMis",    int'(busA.mismatch), 0);

      // Saturation (ERR_W=2) and clear
      feed(2); feed(3);
      feed(7); feed(5); feed(7); feed(6); feed(7);
      feed(3); feed(7); feed(5); feed(7); feed(6);
      checkOutput("satB", int'(busB.err_count), 3);
      checkOutput("satA", int'(busA.err_count), 5);
      applyStimulus(1'b0, 1'b1, 7, 1'b1);
      checkOutput("clrMisB", int'(busB.err_count), 1);
      checkOutput("clrMisA", int'(busA.err_count), 1);
      applyStimulus(1'b0, 1'b1, 3, 1'b1);
      checkOutput("clrB", int'(busB.err_count), 0);
      checkOutput("clrA", int'(busA.err_count), 0);

      // Reset mid-lock with err_count=5
      feed(7); feed(5); feed(7); feed(6); feed(7);
      feed(3); feed(7); feed(5); feed(7); feed(6);
      checkOutput("preRstErr", int'(busA.err_count), 5);
      applyStimulus(1'b1, 1'b1, 2, 1'b0);
      checkOutput("midRstLocked", int'(busA.locked),    0);
      checkOutput("midRstErr",    int'(busA.err_count), 0);
      checkOutput("midRstExpect", int'(busA.expected),  0);
      feed(1); feed(3); feed(7);
      checkOutput("trackToHunt", int'(busA.locked), 0);
      feed(1); feed(6); feed(2); feed(3);
      checkOutput("relock",       int'(busA.locked),   1);
      checkOutput("relockExpect", int'(busA.expected), 4);

      // Mostly-correct random stream with occasional glitches and clears
      for (int i = 0; i < 60; i++) begin
         int  n;
         bit  v;
         bit  c;
         v = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 4) != 0 && nextTab[mPrev] != 0)
            n = nextTab[mPrev];
         else
            n = $urandom_range(0, 7);
         applyStimulus(1'b0, v, n, c);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
